// File: rtl/exc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exc_pkg
//  Description : Shared ExcCode values, sequencer state encoding and the
//                default exception handler vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package exc_pkg;

    typedef logic [2:0] state_t;

    localparam logic [4:0] c_exc_int  = 5'd0;
    localparam logic [4:0] c_exc_adel = 5'd4;
    localparam logic [4:0] c_exc_ades = 5'd5;
    localparam logic [4:0] c_exc_ri   = 5'd10;
    localparam logic [4:0] c_exc_ov   = 5'd12;

    localparam state_t c_st_idle     = 3'd0;
    localparam state_t c_st_entry    = 3'd1;
    localparam state_t c_st_flush    = 3'd2;
    localparam state_t c_st_redirect = 3'd3;
    localparam state_t c_st_eret_clr = 3'd4;

    localparam logic [31:0] c_default_handler_addr = 32'h0000_4180;

endpackage
`default_nettype wire

// File: rtl/hwint_sync.sv
`default_nettype none
// ============================================================================
//  Module      : hwint_sync
//  Description : Multi-flop synchroniser for asynchronous level interrupt lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module hwint_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    // Stage 0 occupies the low WIDTH bits; the oldest sample sits at the top.
    logic [SYNC_STAGES*WIDTH-1:0] chain_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[(SYNC_STAGES-1)*WIDTH-1:0], async_i};
        end
    end

    assign sync_o = chain_q[SYNC_STAGES*WIDTH-1 -: WIDTH];

endmodule
`default_nettype wire

// File: rtl/exc_int_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : exc_int_sequencer
//  Description : Arbitrates interrupt / exception / ERET in the M stage, drives
//                the CP0 update strobes and sequences pipeline flush/redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module exc_int_sequencer
    import exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = c_default_handler_addr,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  hwint_raw,
    input  logic        m_valid,
    input  logic [4:0]  m_exc_code,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic        m_eret,
    input  logic [5:0]  sr_im,
    input  logic        sr_ie,
    input  logic        sr_exl,
    input  logic [31:0] epc,
    output logic [5:0]  cp0_hwint,
    output logic [4:0]  cp0_exc_code,
    output logic [31:0] cp0_pc,
    output logic        cp0_bd,
    output logic        cp0_entry,
    output logic        cp0_exl_clr,
    output logic        flush,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam logic [2:0] c_flush_load = 3'(FLUSH_CYCLES - 1);

    state_t      state_q,  state_d;
    logic [4:0]  code_q,   code_d;
    logic [31:0] pc_q,     pc_d;
    logic        bd_q,     bd_d;
    logic [31:0] target_q, target_d;
    logic [31:0] rpc_q,    rpc_d;
    logic [2:0]  cnt_q,    cnt_d;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_eret_req;

    hwint_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (6)
    ) u_hwint_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (hwint_raw),
        .sync_o  (cp0_hwint)
    );

    assign w_int_req  = m_valid & sr_ie & ~sr_exl & (|(cp0_hwint & sr_im));
    assign w_exc_req  = m_valid & ~sr_exl & (m_exc_code != c_exc_int);
    assign w_eret_req = m_valid & m_eret & (m_exc_code == c_exc_int);

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        pc_d     = pc_q;
        bd_d     = bd_q;
        target_d = target_q;
        rpc_d    = rpc_q;
        cnt_d    = cnt_q;
        case (state_q)
            c_st_idle: begin
                // An interrupt is charged with ExcCode 0 even if M also faults.
                if (w_int_req || w_exc_req) begin
                    state_d  = c_st_entry;
                    code_d   = w_int_req ? c_exc_int : m_exc_code;
                    pc_d     = m_pc;
                    bd_d     = m_bd;
                    target_d = HANDLER_ADDR;
                end else if (w_eret_req) begin
                    state_d  = c_st_eret_clr;
                    target_d = epc;
                end
            end
            c_st_entry, c_st_eret_clr: begin
                state_d = c_st_flush;
                cnt_d   = c_flush_load;
            end
            c_st_flush: begin
                if (cnt_q == 3'd0) begin
                    state_d = c_st_redirect;
                    rpc_d   = target_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            c_st_redirect: begin
                state_d = c_st_idle;
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= c_st_idle;
            code_q   <= '0;
            pc_q     <= '0;
            bd_q     <= 1'b0;
            target_q <= HANDLER_ADDR;
            rpc_q    <= HANDLER_ADDR;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            pc_q     <= pc_d;
            bd_q     <= bd_d;
            target_q <= target_d;
            rpc_q    <= rpc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs decode straight from state so an async reset drops them at once.
    assign cp0_entry    = (state_q == c_st_entry);
    assign cp0_exl_clr  = (state_q == c_st_eret_clr);
    assign cp0_exc_code = cp0_entry ? code_q : '0;
    assign cp0_pc       = cp0_entry ? pc_q   : '0;
    assign cp0_bd       = cp0_entry & bd_q;
    assign stall        = (state_q == c_st_entry) || (state_q == c_st_eret_clr) ||
                          (state_q == c_st_flush);
    assign redirect     = (state_q == c_st_redirect);
    assign flush        = stall | redirect;
    assign redirect_pc  = rpc_q;

endmodule
`default_nettype wire

// File: tb/tb_exc_int_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exc_int_sequencer
//  Description : Scoreboard bench for exc_int_sequencer with a minimal CP0 EXL model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_int_sequencer;

    localparam int          FC = 3;
    localparam int          SS = 2;
    localparam logic [31:0] HA = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  hwint_raw = '0;
    logic        m_valid = 1'b0;
    logic [4:0]  m_exc_code = '0;
    logic [31:0] m_pc = '0;
    logic        m_bd = 1'b0;
    logic        m_eret = 1'b0;
    logic [5:0]  sr_im = 6'b000100;
    logic        sr_ie = 1'b1;
    logic        sr_exl;
    logic [31:0] epc = '0;
    logic [5:0]  cp0_hwint;
    logic [4:0]  cp0_exc_code;
    logic [31:0] cp0_pc;
    logic        cp0_bd;
    logic        cp0_entry;
    logic        cp0_exl_clr;
    logic        flush;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    exc_int_sequencer #(
        .HANDLER_ADDR (HA),
        .FLUSH_CYCLES (FC),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hwint_raw    (hwint_raw),
        .m_valid      (m_valid),
        .m_exc_code   (m_exc_code),
        .m_pc         (m_pc),
        .m_bd         (m_bd),
        .m_eret       (m_eret),
        .sr_im        (sr_im),
        .sr_ie        (sr_ie),
        .sr_exl       (sr_exl),
        .epc          (epc),
        .cp0_hwint    (cp0_hwint),
        .cp0_exc_code (cp0_exc_code),
        .cp0_pc       (cp0_pc),
        .cp0_bd       (cp0_bd),
        .cp0_entry    (cp0_entry),
        .cp0_exl_clr  (cp0_exl_clr),
        .flush        (flush),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // CP0 EXL bit: set by entry, cleared by ERET
    always @(posedge clk or posedge reset) begin
        if (reset)            sr_exl <= 1'b0;
        else if (cp0_entry)   sr_exl <= 1'b1;
        else if (cp0_exl_clr) sr_exl <= 1'b0;
    end

    typedef struct {
        int          kind;   // 0 entry, 1 exl_clr, 2 redirect
        int          cyc;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        bd;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   fl_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input int c, input logic [4:0] code, input logic [31:0] pc,
                              input logic bd);
        q.push_back('{0, c, code, pc, bd});
        q.push_back('{2, c + FC + 1, 5'd0, HA, 1'b0});
    endtask

    task automatic do_eret(input logic [31:0] addr);
        m_valid    = 1'b1;
        m_eret     = 1'b1;
        m_exc_code = 5'd0;
        epc        = addr;
        q.push_back('{1, cyc + 1, 5'd0, 32'd0, 1'b0});
        q.push_back('{2, cyc + 1 + FC + 1, 5'd0, addr, 1'b0});
        step(1);
        m_eret  = 1'b0;
        m_valid = 1'b0;
        step(12);
    endtask

    // Monitor: pops the scoreboard whenever the DUT emits a strobe
    always @(negedge clk) begin
        int   k;
        exp_t e;
        if (!reset && (cp0_entry || cp0_exl_clr || redirect)) begin
            k = cp0_entry ? 0 : (cp0_exl_clr ? 1 : 2);
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", k, cyc);
            end else begin
                e = q.pop_front();
                chk("event_kind", k, e.kind);
                chk("event_cycle", cyc, e.cyc);
                if (k == 0) begin
                    chk("entry_code", {27'd0, cp0_exc_code}, {27'd0, e.code});
                    chk("entry_pc", cp0_pc, e.pc);
                    chk("entry_bd", {31'd0, cp0_bd}, {31'd0, e.bd});
                    chk("entry_flush_stall", {30'd0, flush, stall}, 32'd3);
                end else if (k == 2) begin
                    chk("redirect_pc", redirect_pc, e.pc);
                    chk("redirect_flush_stall", {30'd0, flush, stall}, 32'd2);
                    chk("flush_run_len", fl_run, FC + 1);
                end
            end
        end
        if (redirect)           fl_run = 0;
        else if (flush && stall) fl_run++;
        else                    fl_run = 0;
    end

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_entry", {31'd0, cp0_entry}, 32'd0);
        chk("rst_exl_clr", {31'd0, cp0_exl_clr}, 32'd0);
        chk("rst_hwint", {26'd0, cp0_hwint}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, HA);
        #9 reset = 1'b0;
        step(3);

        // Interrupt on line 2, synchronised before it reaches M
        hwint_raw = 6'b000100;
        m_valid   = 1'b1;
        m_pc      = 32'h3010;
        m_bd      = 1'b0;
        push_entry(cyc + SS + 1, 5'd0, 32'h3010, 1'b0);
        step(SS + 1);
        hwint_raw = '0;
        m_valid   = 1'b0;
        step(12);
        do_eret(32'h3040);

        // Overflow in a delay slot
        m_valid    = 1'b1;
        m_exc_code = 5'd12;
        m_pc       = 32'h3024;
        m_bd       = 1'b1;
        push_entry(cyc + 1, 5'd12, 32'h3024, 1'b1);
        step(1);
        m_valid    = 1'b0;
        m_exc_code = 5'd0;
        m_bd       = 1'b0;
        step(12);
        do_eret(32'h3100);

        // Interrupt and AdEL in the same cycle: interrupt wins
        hwint_raw = 6'b000100;
        m_valid   = 1'b0;
        step(SS);
        m_valid    = 1'b1;
        m_exc_code = 5'd4;
        m_pc       = 32'h3030;
        push_entry(cyc + 1, 5'd0, 32'h3030, 1'b0);
        step(1);
        m_valid    = 1'b0;
        m_exc_code = 5'd0;
        hwint_raw  = '0;
        step(12);
        do_eret(32'h3104);

        // Pending interrupt held off by three bubbles
        hwint_raw = 6'b000100;
        m_valid   = 1'b0;
        step(SS + 3);
        m_valid = 1'b1;
        m_pc    = 32'h3050;
        push_entry(cyc + 1, 5'd0, 32'h3050, 1'b0);
        step(1);
        m_valid   = 1'b0;
        hwint_raw = '0;
        step(12);
        do_eret(32'h3108);

        // Reserved instruction, then reset in the middle of FLUSH
        m_valid    = 1'b1;
        m_exc_code = 5'd10;
        m_pc       = 32'h3060;
        q.push_back('{0, cyc + 1, 5'd10, 32'h3060, 1'b0});
        step(1);
        m_valid    = 1'b0;
        m_exc_code = 5'd0;
        step(1);
        chk("flush_before_reset", {31'd0, flush}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_flush", {31'd0, flush}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_redirect", {31'd0, redirect}, 32'd0);
        chk("mid_rst_entry", {31'd0, cp0_entry}, 32'd0);
        chk("mid_rst_redirect_pc", redirect_pc, HA);
        #10 reset = 1'b0;
        step(12);
        chk("post_rst_flush", {31'd0, flush}, 32'd0);
        chk("queue_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
